// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: read-tag owner and tag record.
// Used by mem_port_arbiter and mem_arb_tag_pipe.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam logic [2:0] F3_LW = 3'b010;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth shift register of read tags, one stage per cycle of memory read latency.
// Synchronous active-low clear drops every in-flight tag.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push_tag,
  output rd_tag_t tail_tag
);

  rd_tag_t stage_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_tag = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and data; routes read returns by tag.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of data priority + anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              write_mem,
  output logic [2:0]        funct3,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data
);

  logic    grant_if;
  logic    grant_d;
  rd_tag_t push_tag;
  rd_tag_t tail_tag;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when fetch holds priority, i.e. data was granted most recently.
  logic prio_if_q;

  always_comb begin
    grant_d  = rst_n && d_req && (!if_req || !prio_if_q);
    grant_if = rst_n && if_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_if_q <= 1'b0;
    end else if (grant_d) begin
      prio_if_q <= 1'b1;
    end else if (grant_if) begin
      prio_if_q <= 1'b0;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_q;
  logic             starve_hit;

  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_d  = rst_n && d_req && !(if_req && starve_hit);
    grant_if = rst_n && if_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (if_req && !grant_if) begin
      starve_q <= starve_q + 1'b1;
    end else begin
      starve_q <= '0;
    end
  end
`endif

  assign if_gnt = grant_if;
  assign d_gnt  = grant_d;

  always_comb begin
    write_mem     = 1'b0;
    funct3        = '0;
    write_address = '0;
    read_address  = '0;
    write_data    = '0;
    unique case (1'b1)
      grant_d: begin
        write_mem     = d_we;
        funct3        = d_funct3;
        write_address = d_addr;
        read_address  = d_addr;
        write_data    = d_wdata;
      end
      grant_if: begin
        funct3        = F3_LW;
        write_address = if_addr;
        read_address  = if_addr;
      end
      default: ;
    endcase
  end

  // Stores and idle cycles still advance the pipe as empty slots.
  always_comb begin
    push_tag.valid = grant_if || (grant_d && !d_we);
    push_tag.owner = grant_d ? OWN_D : OWN_IF;
  end

  mem_arb_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_tag(push_tag),
    .tail_tag(tail_tag)
  );

  assign if_rvalid = rst_n && tail_tag.valid && (tail_tag.owner == OWN_IF);
  assign d_rvalid  = rst_n && tail_tag.valid && (tail_tag.owner == OWN_D);
  assign if_rdata  = if_rvalid ? read_data : '0;
  assign d_rdata   = d_rvalid ? read_data : '0;

endmodule
